// File: rtl/pll_clk_supervisor_if.sv
// pll_clk_supervisor_if: signal bundle between the PLL clock supervisor and
// the logic that consumes its reset/ready/strobe outputs.
//   pll_locked  raw PLL lock (asynchronous to the core clock)
//   loss_clr    synchronous clear of lock_lost / loss_count
//   rst_out_n   registered core reset, active low
//   ready       supervisor is in RUN
//   en          one-cycle clock-enable strobes, one per channel
//   lock_lost   sticky lock-loss flag
//   loss_count  saturating lock-loss count
// master: drives pll_locked/loss_clr and observes the rest.
// slave:  the supervisor itself.
interface pll_clk_supervisor_if #(
    parameter int NUM_CH = 2,
    parameter int LOSS_W = 8
);
    logic              pll_locked;
    logic              loss_clr;
    logic              rst_out_n;
    logic              ready;
    logic [NUM_CH-1:0] en;
    logic              lock_lost;
    logic [LOSS_W-1:0] loss_count;

    modport master (
        output pll_locked, loss_clr,
        input  rst_out_n, ready, en, lock_lost, loss_count
    );

    modport slave (
        input  pll_locked, loss_clr,
        output rst_out_n, ready, en, lock_lost, loss_count
    );
endinterface

// File: rtl/pll_clk_supervisor.sv
// pll_clk_supervisor: synchronises the PLL lock, sequences the core reset
// (WAIT_LOCK -> STABILISE -> RELEASE -> RUN), counts lock losses seen in RUN
// and produces NUM_CH divided clock-enable strobes while in RUN.
//   clock_in  core clock (PLL output)
//   resetn    asynchronous active-low reset
//   sup       pll_clk_supervisor_if slave modport (lock in, reset/ready/
//             strobes/loss status out)

// One strobe channel. run_nxt is the supervisor's next-cycle RUN indication,
// so en is registered and lines up with the cycles where ready is high.
module pll_clk_en_ch #(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] DIV   = CNT_W'(60)
) (
    input  logic clock_in,
    input  logic resetn,
    input  logic run_nxt,
    output logic en
);
    localparam logic             FAST = (DIV <= CNT_W'(1));
    localparam logic [CNT_W-1:0] LAST = DIV - CNT_W'(1);

    logic [CNT_W-1:0] c;
    logic             hit;

    // c holds the number of RUN cycles already elapsed (mod DIV) when the
    // next edge is evaluated, so the strobe lands in RUN cycle DIV.
    assign hit = FAST || (c == LAST);

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            c  <= '0;
            en <= 1'b0;
        end else begin
            en <= run_nxt & hit;
            if (!run_nxt || hit) c <= '0;
            else                 c <= c + 1'b1;
        end
    end
endmodule

module pll_clk_supervisor #(
    parameter int                     NUM_CH      = 2,
    parameter int                     CNT_W       = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIVS       = {16'd60000, 16'd60},
    parameter int                     LOCK_STABLE = 256,
    parameter int                     RST_HOLD    = 16,
    parameter int                     LOSS_W      = 8
) (
    input  logic               clock_in,
    input  logic               resetn,
    pll_clk_supervisor_if.slave sup
);
    typedef enum logic [1:0] {WAIT_LOCK, STABILISE, RELEASE, RUN} state_t;

    // One counter serves both the stability window and the reset hold.
    localparam int             MAXC     = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
    localparam int             CW       = $clog2(MAXC + 1);
    localparam logic [CW-1:0]  STAB_END = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0]  HOLD_END = CW'(RST_HOLD - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [1:0]        sync;
    logic              lock_s;
    logic              rst_q, ready_q;
    logic              lost_q, lost_nxt;
    logic [LOSS_W-1:0] loss_q, loss_nxt;
    logic              run_nxt;

    assign lock_s = sync[1];

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            sync    <= 2'b00;
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_q   <= 1'b0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            sync    <= {sync[0], sup.pll_locked};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            // Outputs come from next-state so they change on the same edge
            // as the state itself.
            rst_q   <= (state_nxt == RELEASE) || (state_nxt == RUN);
            ready_q <= (state_nxt == RUN);
            lost_q  <= lost_nxt;
            loss_q  <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_nxt  = lost_q;
        loss_nxt  = loss_q;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABILISE;
                    cnt_nxt   = '0;
                end
            end
            STABILISE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STAB_END) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == HOLD_END) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) state_nxt = WAIT_LOCK;
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        // A loss on the same cycle as a clear wins: flag set, count restarts at 1.
        if ((state == RUN) && !lock_s) begin
            lost_nxt = 1'b1;
            if (sup.loss_clr)   loss_nxt = LOSS_W'(1);
            else if (!(&loss_q)) loss_nxt = loss_q + 1'b1;
        end else if (sup.loss_clr) begin
            lost_nxt = 1'b0;
            loss_nxt = '0;
        end
    end

    assign run_nxt = (state_nxt == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_clk_en_ch #(
            .CNT_W (CNT_W),
            .DIV   (DIVS[i*CNT_W +: CNT_W])
        ) u_ch (
            .clock_in (clock_in),
            .resetn   (resetn),
            .run_nxt  (run_nxt),
            .en       (sup.en[i])
        );
    end

    assign sup.rst_out_n  = rst_q;
    assign sup.ready      = ready_q;
    assign sup.lock_lost  = lost_q;
    assign sup.loss_count = loss_q;
endmodule

// File: tb/tb_pll_clk_supervisor.sv
// tb_pll_clk_supervisor: randomized lock/clear stimulus checked every cycle
// against a timing model. The model tracks r, the run length of consecutive
// synchronised-lock samples; the supervisor's outputs are pure functions of r
// because any lock drop returns it to the start of the sequence.
module tb_pll_clk_supervisor;
    localparam int NCH = 4;
    localparam int LS  = 256;
    localparam int RH  = 16;
    localparam int LW  = 2;
    localparam logic [NCH*16-1:0] DIVS = {16'd0, 16'd1, 16'd600, 16'd60};

    int dv [NCH] = '{60, 600, 1, 0};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic lk = 1'b0;
    logic clr = 1'b0;
    bit   rnd_clr = 1'b0;

    pll_clk_supervisor_if #(.NUM_CH(NCH), .LOSS_W(LW)) bus ();
    assign bus.pll_locked = lk;
    assign bus.loss_clr   = clr;

    pll_clk_supervisor #(
        .NUM_CH(NCH), .CNT_W(16), .DIVS(DIVS),
        .LOCK_STABLE(LS), .RST_HOLD(RH), .LOSS_W(LW)
    ) dut (
        .clock_in (clk),
        .resetn   (resetn),
        .sup      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // model state
    int r;
    bit h1, h2;
    bit m_lost;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic bit exp_rst();
        return r >= LS + 1;
    endfunction

    function automatic bit exp_rdy();
        return r >= LS + 1 + RH;
    endfunction

    function automatic logic [31:0] exp_en();
        logic [31:0] v;
        int m;
        v = '0;
        if (exp_rdy()) begin
            m = r - (LS + RH);  // 1 in the first RUN cycle
            for (int i = 0; i < NCH; i++)
                if (dv[i] <= 1 || (m % dv[i]) == 0) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        r = 0; h1 = 0; h2 = 0; m_lost = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock edge.
    task automatic model_step();
        bit seen, was_run;
        if (!resetn) begin
            model_reset();
            return;
        end
        seen    = h2;        // lock as seen two edges after sampling
        h2      = h1;
        h1      = lk;
        was_run = exp_rdy();
        r       = seen ? r + 1 : 0;
        if (!seen && was_run) begin
            m_lost = 1;
            if (clr) m_cnt = 1;
            else if (m_cnt < (1 << LW) - 1) m_cnt = m_cnt + 1;
        end else if (clr) begin
            m_lost = 0;
            m_cnt  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("rst_out_n",  32'(bus.rst_out_n),  32'(exp_rst()));
        chk("ready",      32'(bus.ready),      32'(exp_rdy()));
        chk("en",         32'(bus.en),         exp_en());
        chk("lock_lost",  32'(bus.lock_lost),  32'(m_lost));
        chk("loss_count", 32'(bus.loss_count), 32'(m_cnt));
        if (rnd_clr) clr = ($urandom_range(0, 15) == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise the lock and measure edges to rst_out_n, then to ready.
    task automatic lock_seq(input string tag);
        int n, m;
        lk = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.rst_out_n && n < 2000);
        chk({tag, "_rst_lat"}, 32'(n), 32'(LS + 3));
        m = 0;
        while (!bus.ready && m < 200) begin tick(); m++; end
        chk({tag, "_rdy_lat"}, 32'(m), 32'(RH));
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        ticks(3);
        chk("rst_state", 32'({bus.rst_out_n, bus.ready, bus.en, bus.lock_lost, bus.loss_count}), 32'd0);
        resetn = 1'b1;
        ticks(10);

        // lock from reset, then strobes over two ch1 periods
        lock_seq("lock0");
        ticks(1300);

        // loss in RUN
        lk = 1'b0;
        ticks(3);
        chk("run_loss_rst", 32'(bus.rst_out_n), 32'd0);
        chk("run_loss_cnt", 32'(bus.loss_count), 32'd1);
        ticks(5);

        // early drop during STABILISE is not counted
        lk = 1'b1;
        ticks(100);
        lk = 1'b0;
        ticks(10);
        chk("early_cnt", 32'(bus.loss_count), 32'd1);
        chk("early_rst", 32'(bus.rst_out_n), 32'd0);
        lock_seq("relock");
        ticks(50);

        // saturation: 5 more RUN losses
        for (int k = 0; k < 5; k++) begin
            lk = 1'b0; ticks(6);
            lk = 1'b1; ticks(300);
        end
        lk = 1'b0; ticks(6);
        chk("sat_cnt", 32'(bus.loss_count), 32'd3);

        // clear alone
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_cnt", 32'(bus.loss_count), 32'd0);
        chk("clr_flag", 32'(bus.lock_lost), 32'd0);

        // clear coincident with a loss event (third edge after the drop)
        lk = 1'b1; ticks(300);
        lk = 1'b0; ticks(2);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_loss_cnt", 32'(bus.loss_count), 32'd1);
        chk("clr_loss_flag", 32'(bus.lock_lost), 32'd1);
        ticks(4);

        // random lock episodes with random clears
        rnd_clr = 1'b1;
        for (int k = 0; k < 12; k++) begin
            lk = 1'b1; ticks($urandom_range(1, 700));
            lk = 1'b0; ticks($urandom_range(1, 8));
        end
        rnd_clr = 1'b0;
        clr = 1'b0;

        // async reset mid-RUN
        lk = 1'b1;
        ticks(400);
        #2 resetn = 1'b0;
        #1 chk("async_rst", 32'({bus.rst_out_n, bus.ready, bus.en, bus.lock_lost, bus.loss_count}), 32'd0);
        ticks(3);
        resetn = 1'b1;
        lock_seq("post_rst");
        ticks(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
